// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ssub_state_e;

   // The counter only has to reach width-1, so clog2(width) bits suffice (min 1).
   function automatic int ssub_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first through one full-subtractor
// cell, with valid/ready handshakes on the operand and result sides.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);

   localparam int CNT_W = ssub_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   ssub_state_e      state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             cell_d, cell_bout;
   logic             last_bit;

   full_subtractor u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (cnt_q == LAST_BIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // In RUN a_q[0]/b_q[0] hold the current bit; on the last bit they are the sign bits.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      diff_d = diff_q;
      cnt_d  = cnt_q;
      br_d   = br_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      if (state_q == IDLE && in_valid) begin
         a_d   = a;
         b_d   = b;
         br_d  = bin;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         a_d    = a_q >> 1;
         b_d    = b_q >> 1;
         diff_d = {cell_d, diff_q[WIDTH-1:1]};
         br_d   = cell_bout;
         cnt_d  = cnt_q + 1'b1;
         if (last_bit) begin
            bout_d = cell_bout;
            ovf_d  = (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_d);
         end
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule
